// File: rtl/rx_frame_ctrl.sv
// Receive-side frame controller: gates the serial line into a UART receiver, checks frame
// parity and buffers good payloads in a small FIFO. Define RX_FRAME_CTRL_ERR_CNT_EN to add err_cnt.
module rx_frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ODD_PARITY = 1
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic                          line_in,
  output logic                          rx_line,
  input  logic                          rx_done,
  input  logic [DATA_WIDTH:0]           rx_data,
  input  logic                          en,
  input  logic                          clr,
  output logic                          m_valid,
  output logic [DATA_WIDTH-1:0]         m_data,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          parity_err,
  output logic                          overflow
`ifdef RX_FRAME_CTRL_ERR_CNT_EN
  ,
  output logic [7:0]                    err_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                  rx_done_p0;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         count;
  logic                  parity_err_q;
  logic                  overflow_q;

  logic frame_edge, frame_good, frame_bad;
  logic full, push, pop, drop_ovf;

  function automatic logic parity_ok(input logic [DATA_WIDTH:0] d);
    return (^d) == (ODD_PARITY != 0);
  endfunction

  // Stage 0: frame detection on the rising edge of rx_done, only while running
  assign frame_edge = (state_q == RUN) && rx_done && !rx_done_p0;
  assign frame_good = frame_edge && parity_ok(rx_data);
  assign frame_bad  = frame_edge && !parity_ok(rx_data);

  assign full     = (count == LW'(FIFO_DEPTH));
  assign pop      = m_valid && m_ready && !clr;
  assign push     = frame_good && (!full || pop) && !clr;
  assign drop_ovf = frame_good && full && !pop && !clr;

  // History resets high so a receiver already asserting rx_done is not taken as a new frame
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) rx_done_p0 <= 1'b1;
    else       rx_done_p0 <= rx_done;
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data[DATA_WIDTH-1:0];
  end

  // Stage 1: status flags registered from the detection stage
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      parity_err_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      parity_err_q <= frame_bad && !clr;
      if (clr)           overflow_q <= 1'b0;
      else if (drop_ovf) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN: begin
        if (drop_ovf) state_d = HALT;
        else if (!en) state_d = IDLE;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

`ifdef RX_FRAME_CTRL_ERR_CNT_EN
  always_ff @(posedge clk or negedge arst) begin
    if (!arst)                                             err_cnt <= 8'd0;
    else if (clr)                                          err_cnt <= 8'd0;
    else if ((frame_bad || drop_ovf) && err_cnt != 8'hFF)  err_cnt <= err_cnt + 8'd1;
  end
`endif

  // Receiver sees an idle line unless running, so it cannot assemble frames while parked
  assign rx_line    = (state_q == RUN) ? line_in : 1'b1;
  assign m_valid    = (count != '0);
  assign m_data     = m_valid ? mem[rd_ptr] : '0;
  assign level      = count;
  assign parity_err = parity_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Bench for rx_frame_ctrl: directed scenarios then randomized traffic, all checked against
// a queue-based behavioural model.
module tb_rx_frame_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          arst;
  logic          line_in, rx_line, rx_done, en, clr, m_valid, m_ready;
  logic          parity_err, overflow;
  logic [DW:0]   rx_data;
  logic [DW-1:0] m_data;
  logic [2:0]    level;
`ifdef RX_FRAME_CTRL_ERR_CNT_EN
  logic [7:0]    err_cnt;
`endif

  rx_frame_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ODD_PARITY(1)) dut (
    .clk(clk), .arst(arst), .line_in(line_in), .rx_line(rx_line),
    .rx_done(rx_done), .rx_data(rx_data), .en(en), .clr(clr),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .level(level),
    .parity_err(parity_err), .overflow(overflow)
`ifdef RX_FRAME_CTRL_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: 0 = idle, 1 = running, 2 = halted
  logic [7:0] mq[$];
  int         m_state;
  bit         m_prev, m_ovf, m_perr;
  int         m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] mkf(input logic [7:0] b, input bit good);
    logic p;
    p = ~(^b);
    if (!good) p = ~p;
    return {p, b};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_state = 0;
    m_prev  = 1'b1;
    m_ovf   = 1'b0;
    m_perr  = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic model_step();
    bit do_pop, edge_seen, good;
    int size_before;
    size_before = mq.size();
    do_pop      = (size_before > 0) && m_ready;
    edge_seen   = (m_state == 1) && rx_done && !m_prev;
    good        = ($countones(rx_data) % 2) == 1;
    m_prev      = rx_done;
    m_perr      = 1'b0;
    if (clr) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_state = 0;
      m_cnt   = 0;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (edge_seen) begin
        if (!good) begin
          m_perr = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end else if (size_before < DEPTH || do_pop) begin
          mq.push_back(rx_data[7:0]);
        end else begin
          m_ovf   = 1'b1;
          m_state = 2;
          if (m_cnt < 255) m_cnt++;
        end
      end
      if (m_state == 0 && en)       m_state = 1;
      else if (m_state == 1 && !en) m_state = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/valid"}, m_valid, (mq.size() > 0));
    chk({tag, "/data"}, m_data, (mq.size() > 0) ? mq[0] : 8'h00);
    chk({tag, "/level"}, level, mq.size());
    chk({tag, "/perr"}, parity_err, m_perr);
    chk({tag, "/ovf"}, overflow, m_ovf);
    chk({tag, "/line"}, rx_line, (m_state == 1) ? line_in : 1'b1);
`ifdef RX_FRAME_CTRL_ERR_CNT_EN
    chk({tag, "/errcnt"}, err_cnt, m_cnt);
`endif
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2;
    arst = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #2;
    arst = 1'b1;
  endtask

  initial begin
    arst = 1'b0; line_in = 1'b1; rx_done = 1'b0; rx_data = '0;
    en = 1'b0; clr = 1'b0; m_ready = 1'b0;
    model_reset();
    #3;
    check_all("reset");
    #4;
    arst = 1'b1;

    // Good frame passes straight through
    en = 1'b1; cycle("to_run");
    line_in = 1'b0; rx_data = 9'h1A5; rx_done = 1'b1; m_ready = 1'b1;
    cycle("good");
    chk("good_valid", m_valid, 1'b1);
    chk("good_data", m_data, 8'hA5);
    chk("good_line", rx_line, 1'b0);
    rx_done = 1'b0; cycle("good_pop");
    chk("good_drained", level, 3'd0);

    // Bad parity frame
    rx_data = 9'h0A5; rx_done = 1'b1; cycle("bad");
    chk("bad_pulse", parity_err, 1'b1);
    chk("bad_level", level, 3'd0);
    rx_done = 1'b0; cycle("bad_after");
    chk("bad_pulse_end", parity_err, 1'b0);
`ifdef RX_FRAME_CTRL_ERR_CNT_EN
    chk("bad_errcnt", err_cnt, 8'd1);
`endif

    // Overflow into HALT, then drain in order
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rx_data = mkf(8'(8'h11 * (i + 1)), 1'b1); rx_done = 1'b1; cycle("fill");
      rx_done = 1'b0; cycle("fill_gap");
    end
    chk("ovf_level", level, 3'd4);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_line", rx_line, 1'b1);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", m_data, 8'(8'h11 * (i + 1)));
      cycle("drain");
    end
    chk("drain_empty", m_valid, 1'b0);
    cycle("halt_hold");
    clr = 1'b1; cycle("clr");
    clr = 1'b0;
    chk("clr_ovf", overflow, 1'b0);
    chk("clr_line", rx_line, 1'b1);
    cycle("rerun");
    chk("rerun_line", rx_line, 1'b0);

    // Full buffer with pop and push together
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rx_data = mkf(8'(8'h21 + i), 1'b1); rx_done = 1'b1; cycle("fill2");
      rx_done = 1'b0; cycle("fill2_gap");
    end
    rx_data = mkf(8'h66, 1'b1); rx_done = 1'b1; m_ready = 1'b1; cycle("pushpop");
    chk("pushpop_level", level, 3'd4);
    chk("pushpop_ovf", overflow, 1'b0);
    rx_done = 1'b0;
    for (int i = 0; i < 4; i++) cycle("drain2");

    // Held rx_done counts once; edge while disabled ignored
    m_ready = 1'b0;
    rx_data = mkf(8'h3C, 1'b1); rx_done = 1'b1;
    for (int i = 0; i < 3; i++) cycle("held");
    chk("held_level", level, 3'd1);
    rx_done = 1'b0; cycle("held_end");
    en = 1'b0; cycle("disable");
    rx_data = mkf(8'h5A, 1'b1); rx_done = 1'b1; cycle("idle_edge");
    chk("idle_level", level, 3'd1);
    rx_done = 1'b0; cycle("idle_gap");

    // Async reset with data buffered
    en = 1'b1; cycle("to_run2");
    rx_data = mkf(8'h77, 1'b1); rx_done = 1'b1; cycle("second");
    rx_done = 1'b1; cycle("second_hold");
    chk("pre_rst_level", level, 3'd2);
    async_reset("arst");
    chk("arst_level", level, 3'd0);
    chk("arst_valid", m_valid, 1'b0);
    chk("arst_data", m_data, 8'h00);
    chk("arst_line", rx_line, 1'b1);
    cycle("post_arst");
    chk("post_arst_level", level, 3'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      en      = ($urandom_range(0, 9) != 0);
      clr     = ($urandom_range(0, 49) == 0);
      m_ready = ($urandom_range(0, 9) < 4);
      line_in = 1'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        rx_done = ~rx_done;
        if (rx_done) rx_data = mkf(8'($urandom), $urandom_range(0, 4) != 0);
      end
      cycle("rand");
      if ($urandom_range(0, 299) == 0) async_reset("rand_arst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
